// File: rtl/uncache_pkg.sv
`default_nettype none
// ============================================================================
// uncache_pkg : shared types and AXI constants for the uncached data path
// Revision    : 1.0
// ============================================================================
package uncache_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_AR   = 3'd1,
    S_RD_R    = 3'd2,
    S_WR_AW_W = 3'd3,
    S_WR_B    = 3'd4,
    S_DONE    = 3'd5
  } uc_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;

  // Same encoding as the translation stage's data_size.
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  function automatic logic [2:0] axi_size(input logic [1:0] sz);
    return {1'b0, sz};
  endfunction

endpackage
`default_nettype wire

// File: rtl/d_uncache_axi.sv
`default_nettype none
// ============================================================================
// d_uncache_axi : single-beat AXI master for uncached (kseg1/MMIO) loads and
//                 stores; stalls the memory stage until the access completes.
// Revision      : 1.0
// ============================================================================
module d_uncache_axi
  import uncache_pkg::*;
#(
  parameter int                  AXI_ID_W = 4,
  parameter logic [AXI_ID_W-1:0] AXI_ID   = 4'd2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                req,
  input  logic                req_wr,
  input  logic [1:0]          req_size,
  input  logic [31:0]         req_paddr,
  input  logic [3:0]          req_wstrb,
  input  logic [31:0]         req_wdata,
  input  logic                pipe_hold,
  output logic [31:0]         rdata,
  output logic                stall,
  output logic [AXI_ID_W-1:0] arid,
  output logic [31:0]         araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic                arvalid,
  input  logic                arready,
  input  logic [31:0]         rdata_axi,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,
  output logic [AXI_ID_W-1:0] awid,
  output logic [31:0]         awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic                awvalid,
  input  logic                awready,
  output logic [31:0]         wdata,
  output logic [3:0]          wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  uc_state_e   state_q, state_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [31:0] paddr_q;
  logic [1:0]  size_q;
  logic [3:0]  wstrb_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;

  logic        aw_hs;
  logic        w_hs;
  logic        both_done;

  // Error responses and rlast carry no information for a single-beat access.
  logic        unused_resp;
  assign unused_resp = ^{rresp, rlast, bresp};

  assign aw_hs     = awvalid & awready;
  assign w_hs      = wvalid & wready;
  assign both_done = (aw_done_q | aw_hs) & (w_done_q | w_hs);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      S_IDLE:    if (req) state_d = req_wr ? S_WR_AW_W : S_RD_AR;
      S_RD_AR:   if (arready) state_d = S_RD_R;
      S_RD_R:    if (rvalid) state_d = S_DONE;
      S_WR_AW_W: begin
        if (both_done) begin
          state_d   = S_WR_B;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else begin
          aw_done_d = aw_done_q | aw_hs;
          w_done_d  = w_done_q | w_hs;
        end
      end
      S_WR_B:    if (bvalid) state_d = S_DONE;
      // Leaving DONE goes to IDLE only; the lingering req is never re-issued.
      S_DONE:    if (!pipe_hold) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    arvalid = 1'b0;
    rready  = 1'b0;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    bready  = 1'b0;
    stall   = 1'b0;
    case (state_q)
      S_IDLE:    stall = req;
      S_RD_AR:   begin arvalid = 1'b1; stall = 1'b1; end
      S_RD_R:    begin rready = 1'b1; stall = 1'b1; end
      S_WR_AW_W: begin
        awvalid = ~aw_done_q;
        wvalid  = ~w_done_q;
        stall   = 1'b1;
      end
      S_WR_B:    begin bready = 1'b1; stall = 1'b1; end
      default:   stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      paddr_q <= 32'd0;
      size_q  <= 2'd0;
      wstrb_q <= 4'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      if (state_q == S_IDLE && req) begin
        paddr_q <= req_paddr;
        size_q  <= req_size;
        wstrb_q <= req_wstrb;
        wdata_q <= req_wdata;
      end
      if (state_q == S_RD_R && rvalid) begin
        rdata_q <= rdata_axi;
      end
    end
  end

  assign rdata   = rdata_q;

  assign arid    = AXI_ID;
  assign araddr  = paddr_q;
  assign arlen   = AXI_LEN_SINGLE;
  assign arsize  = axi_size(size_q);
  assign arburst = AXI_BURST_INCR;

  assign awid    = AXI_ID;
  assign awaddr  = paddr_q;
  assign awlen   = AXI_LEN_SINGLE;
  assign awsize  = axi_size(size_q);
  assign awburst = AXI_BURST_INCR;

  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = 1'b1;

endmodule
`default_nettype wire
